// File: rtl/arb_mux_pkg.sv
// Shared helpers for the arbitrated N-channel merge mux.
// Index width derivation and one-hot to binary conversion.
package arb_mux_pkg;

  localparam int unsigned MAX_CH = 256;

  // A 2-channel mux still needs a 1-bit index, so never return 0.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : int'($clog2(n));
  endfunction

  // Input must be one-hot or zero; zero maps to index 0.
  function automatic int unsigned onehot_to_idx(input logic [MAX_CH-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx |= i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/nbit_arb_mux_if.sv
// Source/sink bundle of nbit_arb_mux: NCH valid/ready sources merged into one output.
interface nbit_arb_mux_if
  import arb_mux_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32
);

  localparam int unsigned SEL_W = clog2_min1(NCH);

  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_sel;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/arb_grant.sv
// One-hot grant generator: round-robin from ptr when ARB_MUX_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module arb_grant
  import arb_mux_pkg::*;
#(
  parameter  int unsigned NCH   = 4,
  localparam int unsigned SEL_W = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NCH-1:0]   grant
);

`ifdef ARB_MUX_RR_EN
  logic [NCH-1:0] rot;
  logic [NCH-1:0] pe;

  // Rotate so ptr sits at bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    rot   = NCH'({req, req} >> ptr);
    pe    = rot & (~rot + NCH'(1));
    grant = NCH'(({pe, pe} << ptr) >> NCH);
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    grant = req & (~req + NCH'(1));
  end
`endif

endmodule

// File: rtl/nbit_arb_mux.sv
// Arbitrated NCH:1 valid/ready merge with a single registered output stage.
// Build option: ARB_MUX_RR_EN selects round-robin arbitration (default fixed priority).
module nbit_arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  nbit_arb_mux_if.slave bus
);

  localparam int unsigned SEL_W = clog2_min1(NCH);

  logic             load;
  logic             xfer;
  logic [NCH-1:0]   req;
  logic [NCH-1:0]   grant;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  // Requests are masked during reset so no handshake completes under rst.
  assign load = !bus.out_valid || bus.out_ready;
  assign req  = rst ? '0 : bus.in_valid;

  arb_grant #(.NCH(NCH)) u_grant (
    .req   (req),
    .ptr   (ptr),
    .grant (grant)
  );

  assign bus.in_ready = grant & {NCH{load}};
  assign xfer         = |bus.in_ready;

  // AND-OR data select keeps in_data out of the in_ready cone.
  always_comb begin
    gnt_idx  = SEL_W'(onehot_to_idx(MAX_CH'(grant)));
    gnt_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant[i]) gnt_data |= bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
    end else if (load) begin
      bus.out_valid <= xfer;
      if (xfer) begin
        bus.out_data <= gnt_data;
        bus.out_sel  <= gnt_idx;
      end
    end
  end

`ifdef ARB_MUX_RR_EN
  // Next priority goes to the channel after the one just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (gnt_idx == SEL_W'(NCH - 1)) ? '0 : gnt_idx + SEL_W'(1);
    end
  end
`else
  assign ptr = '0;
`endif

endmodule
